cv32e40p_instr_realigner: RTL and testbench
===========================================

# cv32e40p_instr_realigner

Parametrised fetch-side realigner that sits between the instruction prefetch interface and the compressed decoder. It buffers 32-bit fetch words in a DEPTH-entry FIFO and carries a 16-bit residual halfword between words. From these it emits one naturally aligned instruction per handshake, each with its PC and a compressed flag. It handles 32-bit instructions that straddle fetch words, branch targets at halfword offsets, and a build mode without RVC support that flags compressed encodings as illegal.

## Interface
- DEPTH, 2, fetch word FIFO entries; power of two, at least 2
- COMPRESSED_EN, 1, 1 = RVC legal; 0 = any halfword with [1:0]!=2'b11 is flagged illegal_c_o
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- branch_i  in  1  single-cycle flush and redirect
- branch_addr_i  in  32  redirect target; bit 0 ignored
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  FIFO can accept a word
- fetch_rdata_i  in  32  fetch word at the next sequential word-aligned address
- instr_valid_o  out  1  instruction available
- instr_ready_i  in  1  consumer accepts
- instr_rdata_o  out  32  instruction; compressed instructions are zero-extended {16'h0, hw}
- instr_addr_o  out  32  PC of instr_rdata_o
- is_compressed_o  out  1  instruction is 16-bit
- illegal_c_o  out  1  compressed encoding seen while COMPRESSED_EN=0

## Operation
- A fetch word is pushed on fetch_valid_i && fetch_ready_o. A FIFO word is popped when its last needed half is consumed.
- Residual R is 16 bits, with PC register pc.
- States:
  - ALIGNED: instruction starts at the FIFO head W.
  - MISALIGNED: instruction starts at R.
  - SKIP: post-branch; the low half of the next word is discarded.
- ALIGNED, W present, W[1:0]!=11:
  - output {16'h0,W[15:0]}, compressed.
  - On handshake: R<=W[31:16], pop, pc+=2, go MISALIGNED.
- ALIGNED, W present, W[1:0]==11:
  - output W.
  - On handshake: pop, pc+=4, stay ALIGNED.
- MISALIGNED, R[1:0]!=11:
  - output {16'h0,R}, compressed; valid does not depend on the FIFO.
  - On handshake: pc+=2, go ALIGNED.
- MISALIGNED, R[1:0]==11:
  - output {W[15:0],R}; valid only if the FIFO is non-empty.
  - On handshake: R<=W[31:16], pop, pc+=4, stay MISALIGNED.
- SKIP, W present:
  - pop; R<=W[31:16]; go MISALIGNED.
  - No instruction is output during SKIP.
- ALIGNED with an empty FIFO: instr_valid_o=0.
- branch_i:
  - clear FIFO pointers and count.
  - pc<={branch_addr_i[31:1],1'b0}.
  - next state = branch_addr_i[1] ? SKIP : ALIGNED.
- branch_i has priority over any same-cycle push or output handshake:
  - the pushed word is dropped.
  - instr_valid_o is forced 0 that cycle.
- COMPRESSED_EN=0: a compressed halfword behaves as in RVC mode (advance by 2), with illegal_c_o=1 alongside is_compressed_o=1.
- Widths: all pc arithmetic is modulo 2^32; pc=32'hFFFF_FFFE + 2 wraps to 0.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - state=ALIGNED, pc=0, FIFO empty, R=0.
  - instr_valid_o=0, fetch_ready_o=1.
  - instr_rdata_o=0, instr_addr_o=0, is_compressed_o=0, illegal_c_o=0.
- fetch_ready_o = (count != DEPTH), registered-state derived. There is no full-bypass: push while full is impossible.
- Push and pop in the same cycle are legal when not full; the count is unchanged.
- Outputs are combinational from state, R and the FIFO head. A word pushed in cycle N can produce an instruction in cycle N+1.
- SKIP costs one cycle after the word arrives, so the first post-branch instruction appears at N+2 for a halfword-aligned target.
- Outputs hold stable while instr_valid_o && !instr_ready_i, unless branch_i asserts.
- Reset asserted mid-stream clears everything immediately. The pending instruction is lost and no handshake completes.

## Test plan
- Branch to 0x100, push 0x00000013 and 0x00A00093 → two 32-bit instructions at 0x100 and 0x104, is_compressed_o=0.
- Branch to 0x200, push 0x00134505 → 0x4505 @0x200 (compressed) then 0x0013 residual; push 0xFFF00113 → 32-bit {0x0113,0x0013}=0x01130013 @0x202, then R=0xFFF0.
- Branch to 0x302, push 0x4505_0000 → the low half is discarded; 0x4505 @0x302 compressed; the following instruction waits until the next word is pushed.
- DEPTH=2, hold instr_ready_i=0, push 3 words → fetch_ready_o low after two pushes, outputs stable. Release → all instructions drain in order and ready returns high.
- Assert branch_i in the same cycle as an output handshake and a push → neither takes effect; FIFO empty next cycle; pc = new target.
- COMPRESSED_EN=0, branch to 0, push 0x00004505 → illegal_c_o=1, is_compressed_o=1 @0x0; next instruction is at 0x2.

Source files
------------

// File: rtl/cv32e40p_instr_realigner.sv
// Fetch-side realigner: buffers 32-bit fetch words and emits one aligned
// 16/32-bit instruction per handshake, with its PC and a compressed flag.
module cv32e40p_instr_realigner #(
    parameter int DEPTH         = 2,
    parameter bit COMPRESSED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        is_compressed_o,
    output logic        illegal_c_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {S_ALIGNED, S_MISALIGNED, S_SKIP} state_t;

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_cnt;
    logic [15:0]     r_res, w_res_nxt;
    logic [31:0]     r_pc, w_pc_nxt;
    logic [31:0]     w_head, w_rdata;
    logic            w_empty, w_push, w_pop, w_valid, w_comp, w_hs;

    assign w_empty       = (r_cnt == '0);
    assign w_head        = r_mem[r_rptr];
    assign fetch_ready_o = (r_cnt != FULL_CNT);
    // A flush drops any word offered in the same cycle.
    assign w_push        = fetch_valid_i && fetch_ready_o && !branch_i;

    always_comb begin
        w_valid     = 1'b0;
        w_comp      = 1'b0;
        w_rdata     = '0;
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        w_res_nxt   = r_res;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_ALIGNED: begin
                if (!w_empty) begin
                    w_valid = 1'b1;
                    if (w_head[1:0] != 2'b11) begin
                        w_comp  = 1'b1;
                        w_rdata = {16'h0, w_head[15:0]};
                    end else begin
                        w_rdata = w_head;
                    end
                end
            end
            S_MISALIGNED: begin
                // A compressed residual needs nothing from the FIFO.
                if (r_res[1:0] != 2'b11) begin
                    w_valid = 1'b1;
                    w_comp  = 1'b1;
                    w_rdata = {16'h0, r_res};
                end else if (!w_empty) begin
                    w_valid = 1'b1;
                    w_rdata = {w_head[15:0], r_res};
                end
            end
            S_SKIP: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_res_nxt   = w_head[31:16];
                    w_state_nxt = S_MISALIGNED;
                end
            end
            default: ;
        endcase
        if (branch_i) w_valid = 1'b0;
        w_hs = w_valid && instr_ready_i;
        if (w_hs) begin
            w_pc_nxt = r_pc + (w_comp ? 32'd2 : 32'd4);
            if (r_state == S_ALIGNED) begin
                w_pop = 1'b1;
                if (w_comp) begin
                    w_res_nxt   = w_head[31:16];
                    w_state_nxt = S_MISALIGNED;
                end
            end else if (!w_comp) begin
                w_pop     = 1'b1;
                w_res_nxt = w_head[31:16];
            end else begin
                w_state_nxt = S_ALIGNED;
            end
        end
        if (branch_i) begin
            w_pop       = 1'b0;
            w_pc_nxt    = branch_addr_i & ~32'd1;
            w_state_nxt = branch_addr_i[1] ? S_SKIP : S_ALIGNED;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= fetch_rdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ALIGNED;
            r_pc    <= '0;
            r_res   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_res   <= w_res_nxt;
            if (branch_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Data outputs read as zero whenever no instruction is offered.
    assign instr_valid_o   = w_valid;
    assign instr_rdata_o   = w_valid ? w_rdata : 32'h0;
    assign instr_addr_o    = r_pc;
    assign is_compressed_o = w_valid && w_comp;
    assign illegal_c_o     = w_valid && w_comp && !COMPRESSED_EN;
endmodule

// File: tb/tb_cv32e40p_instr_realigner.sv
// Directed bench for the realigner: RVC and non-RVC instances, hand-derived
// expected instruction streams, backpressure, flush and reset cases.
module tb_cv32e40p_instr_realigner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_i = 1'b0, fetch_valid_i = 1'b0, instr_ready_i = 1'b0;
    logic [31:0] branch_addr_i = '0, fetch_rdata_i = '0;
    logic        fetch_ready_o, instr_valid_o, is_compressed_o, illegal_c_o;
    logic [31:0] instr_rdata_o, instr_addr_o;

    logic        nc_branch = 1'b0, nc_fvalid = 1'b0, nc_iready = 1'b0;
    logic [31:0] nc_baddr = '0, nc_fdata = '0;
    logic        nc_fready, nc_ivalid, nc_comp, nc_ill;
    logic [31:0] nc_rdata, nc_addr;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    cv32e40p_instr_realigner #(.DEPTH(2), .COMPRESSED_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_rdata_i(fetch_rdata_i), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i), .instr_rdata_o(instr_rdata_o),
        .instr_addr_o(instr_addr_o), .is_compressed_o(is_compressed_o),
        .illegal_c_o(illegal_c_o));

    cv32e40p_instr_realigner #(.DEPTH(2), .COMPRESSED_EN(1'b0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n), .branch_i(nc_branch), .branch_addr_i(nc_baddr),
        .fetch_valid_i(nc_fvalid), .fetch_ready_o(nc_fready),
        .fetch_rdata_i(nc_fdata), .instr_valid_o(nc_ivalid),
        .instr_ready_i(nc_iready), .instr_rdata_o(nc_rdata),
        .instr_addr_o(nc_addr), .is_compressed_o(nc_comp),
        .illegal_c_o(nc_ill));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] rdata,
                           input logic [31:0] addr, input logic comp);
        chk({tag, " valid"}, {31'h0, instr_valid_o}, 32'd1);
        chk({tag, " rdata"}, instr_rdata_o, rdata);
        chk({tag, " addr"}, instr_addr_o, addr);
        chk({tag, " comp"}, {31'h0, is_compressed_o}, {31'h0, comp});
    endtask

    task automatic branch(input logic [31:0] a);
        branch_i = 1'b1; branch_addr_i = a;
        #1 chk("branch valid low", {31'h0, instr_valid_o}, 32'd0);
        @(posedge clk); #1 branch_i = 1'b0; #1;
    endtask

    task automatic push(input logic [31:0] w);
        fetch_valid_i = 1'b1; fetch_rdata_i = w;
        @(posedge clk); #1 fetch_valid_i = 1'b0; #1;
    endtask

    task automatic take();
        instr_ready_i = 1'b1;
        @(posedge clk); #1 instr_ready_i = 1'b0; #1;
    endtask

    initial begin
        #1;
        chk("rst valid", {31'h0, instr_valid_o}, 32'd0);
        chk("rst fready", {31'h0, fetch_ready_o}, 32'd1);
        chk("rst rdata", instr_rdata_o, 32'h0);
        chk("rst addr", instr_addr_o, 32'h0);
        chk("rst comp", {31'h0, is_compressed_o}, 32'd0);
        chk("rst ill", {31'h0, illegal_c_o}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Two aligned 32-bit instructions.
        branch(32'h100);
        push(32'h0000_0013);
        chk_out("a0", 32'h0000_0013, 32'h100, 1'b0);
        push(32'h00A0_0093);
        take();
        chk_out("a1", 32'h00A0_0093, 32'h104, 1'b0);
        take();
        chk("a empty", {31'h0, instr_valid_o}, 32'd0);

        // Compressed then a 32-bit instruction straddling two words.
        branch(32'h200);
        push(32'h0013_4505);
        chk_out("s0", 32'h0000_4505, 32'h200, 1'b1);
        take();
        chk("s wait", {31'h0, instr_valid_o}, 32'd0);
        push(32'hFFF0_0113);
        chk_out("s1", 32'h0113_0013, 32'h202, 1'b0);
        take();
        chk_out("s2", 32'h0000_FFF0, 32'h206, 1'b1);

        // Halfword-aligned target: low half skipped, N+2 latency.
        branch(32'h302);
        push(32'h4505_0000);
        chk("k skip", {31'h0, instr_valid_o}, 32'd0);
        @(posedge clk); #2;
        chk_out("k0", 32'h0000_4505, 32'h302, 1'b1);
        take();
        chk("k wait", {31'h0, instr_valid_o}, 32'd0);

        // Backpressure with a full 2-entry FIFO.
        branch(32'h400);
        push(32'h0000_0013);
        push(32'h00A0_0093);
        chk("b full", {31'h0, fetch_ready_o}, 32'd0);
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0010_0113;
        @(posedge clk); #2;
        chk_out("b hold", 32'h0000_0013, 32'h400, 1'b0);
        chk("b still full", {31'h0, fetch_ready_o}, 32'd0);
        instr_ready_i = 1'b1;
        @(posedge clk); #2;
        chk_out("b d1", 32'h00A0_0093, 32'h404, 1'b0);
        chk("b fready", {31'h0, fetch_ready_o}, 32'd1);
        @(posedge clk); #1 fetch_valid_i = 1'b0; #1;
        chk_out("b d2", 32'h0010_0113, 32'h408, 1'b0);
        @(posedge clk); #1 instr_ready_i = 1'b0; #1;
        chk("b drained", {31'h0, instr_valid_o}, 32'd0);
        chk("b ready back", {31'h0, fetch_ready_o}, 32'd1);

        // Flush wins over a same-cycle handshake and push.
        branch(32'h500);
        push(32'h0000_0013);
        instr_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00A0_0093;
        branch_i = 1'b1; branch_addr_i = 32'h600;
        #1 chk("f valid low", {31'h0, instr_valid_o}, 32'd0);
        @(posedge clk); #1 branch_i = 1'b0; instr_ready_i = 1'b0; fetch_valid_i = 1'b0; #1;
        chk("f empty", {31'h0, instr_valid_o}, 32'd0);
        chk("f pc", instr_addr_o, 32'h600);
        chk("f fready", {31'h0, fetch_ready_o}, 32'd1);

        // PC wraps past the top of the address space.
        branch(32'hFFFF_FFFE);
        push(32'h0001_0001);
        @(posedge clk); #2;
        chk_out("w0", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        take();
        chk("w pc", instr_addr_o, 32'h0);

        // Non-RVC build flags compressed halfwords.
        nc_branch = 1'b1; nc_baddr = 32'h0;
        @(posedge clk); #1 nc_branch = 1'b0;
        nc_fvalid = 1'b1; nc_fdata = 32'h0000_4505;
        @(posedge clk); #1 nc_fvalid = 1'b0; #1;
        chk("nc valid", {31'h0, nc_ivalid}, 32'd1);
        chk("nc rdata", nc_rdata, 32'h0000_4505);
        chk("nc ill", {31'h0, nc_ill}, 32'd1);
        chk("nc comp", {31'h0, nc_comp}, 32'd1);
        chk("nc addr", nc_addr, 32'h0);
        nc_iready = 1'b1;
        @(posedge clk); #1 nc_iready = 1'b0; #1;
        chk("nc addr2", nc_addr, 32'h2);
        chk("nc ill2", {31'h0, nc_ill}, 32'd1);

        // Mid-stream reset discards the pending instruction.
        branch(32'h700);
        push(32'h0000_0013);
        chk("r pre", {31'h0, instr_valid_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("r valid", {31'h0, instr_valid_o}, 32'd0);
        chk("r addr", instr_addr_o, 32'h0);
        chk("r fready", {31'h0, fetch_ready_o}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
